crc_receiver: RTL and testbench

- Serial CRC frame checker; the receive-side counterpart of the team's serial CRC transmitter.
- Accepts a framed bit stream, MSB first: DATA_W payload bits followed by CRC_W check bits.
- Recomputes the CRC over the payload with an LFSR and compares it against the received check bits.
- Presents the recovered payload, a pass/fail flag and a one-cycle done strobe to the downstream consumer.

---
 rtl/crc_receiver.sv | 118 +++++++++++
 tb/tb_crc_receiver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/crc_receiver.sv
// Serial CRC frame checker. A frame is DATA_W payload bits followed by CRC_W check bits, MSB
// first. The CRC is recomputed over the payload with an LFSR (INIT preset, no final XOR) and
// compared against the received check bits. The verdict, the payload and a one-cycle done
// strobe come out together.
// Optional build macro CRC_ERR_CNT_EN adds a saturating 8-bit count of failed frames (err_cnt).
module crc_receiver #(
  parameter int unsigned      DATA_W = 32,
  parameter int unsigned      CRC_W  = 32,
  parameter logic [CRC_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT   = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              data,
  output logic [DATA_W-1:0] data_out,
  output logic              crc_ok,
  output logic              done,
  output logic              busy
`ifdef CRC_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned MaxW = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int unsigned CntW = $clog2(MaxW) + 1;
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] CrcLast  = CntW'(CRC_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShiftData,
    StShiftCrc,
    StCheck
  } state_t;

  state_t            state_q;
  logic [CRC_W-1:0]  lfsr_q;
  logic [CRC_W-1:0]  lfsr_next;
  logic [DATA_W-1:0] payload_q;
  logic [CRC_W-1:0]  rx_crc_q;
  logic [CntW-1:0]   cnt_q;
  logic              fb;
  logic              match;

  // LFSR next state for one payload bit, plus the final comparison.
  always_comb begin
    fb        = data ^ lfsr_q[CRC_W-1];
    lfsr_next = {lfsr_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    match     = (rx_crc_q == lfsr_q);
  end

  // Frame FSM with registered outputs. The last check bit is captured on the edge that enters
  // StCheck. The verdict is registered on the following edge, so done rises DATA_W+CRC_W+1
  // edges after the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lfsr_q    <= INIT;
      payload_q <= '0;
      rx_crc_q  <= '0;
      cnt_q     <= '0;
      data_out  <= '0;
      crc_ok    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
`ifdef CRC_ERR_CNT_EN
      err_cnt   <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StShiftData;
            lfsr_q  <= INIT;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StShiftData: begin
          payload_q <= {payload_q[DATA_W-2:0], data};
          lfsr_q    <= lfsr_next;
          if (cnt_q == DataLast) begin
            state_q <= StShiftCrc;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StShiftCrc: begin
          rx_crc_q <= {rx_crc_q[CRC_W-2:0], data};
          if (cnt_q == CrcLast) begin
            state_q <= StCheck;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCheck: begin
          done     <= 1'b1;
          data_out <= payload_q;
          crc_ok   <= match;
          busy     <= 1'b0;
          state_q  <= StIdle;
`ifdef CRC_ERR_CNT_EN
          if (!match && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_receiver.sv
// Bench for crc_receiver: directed frames, with expected results queued at drive time and
// compared when done fires.
module tb_crc_receiver;

  localparam logic [31:0] Poly = 32'h04C11DB7;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        data  = 1'b0;
  logic [31:0] data_out;
  logic        crc_ok;
  logic        done;
  logic        busy;
`ifdef CRC_ERR_CNT_EN
  logic [7:0]  err_cnt;
  int          exp_err = 0;
`endif

  always #5 clk = ~clk;

  crc_receiver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data     (data),
    .data_out (data_out),
    .crc_ok   (crc_ok),
    .done     (done),
`ifdef CRC_ERR_CNT_EN
    .busy     (busy),
    .err_cnt  (err_cnt)
`else
    .busy     (busy)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        ok;
    int          c;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC: MSB-first, non-reflected, zero preset, no final XOR.
  function automatic logic [31:0] crc_model(input logic [31:0] d);
    logic [31:0] r;
    logic        f;
    r = 32'h0;
    for (int i = 31; i >= 0; i--) begin
      f = d[i] ^ r[31];
      r = {r[30:0], 1'b0} ^ (f ? Poly : 32'h0);
    end
    return r;
  endfunction

  // Drive one frame; start is re-pulsed during bit 'glitch' when glitch >= 0.
  task automatic send(input logic [31:0] d, input logic [31:0] c, input logic ok,
                      input int glitch);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    data  = 1'b1;
    e.d = d;
    e.ok = ok;
    e.c = cyc + 66;
    sb.push_back(e);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      start = (i == glitch);
      data  = (i < 32) ? d[31-i] : c[63-i];
      if (i == glitch) chk("busy_mid_frame", busy, 1);
    end
    @(negedge clk);
    start = 1'b0;
    data  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  // Output monitor: pops the scoreboard on every done and checks pulse width.
  logic prev_done = 1'b0;
  exp_t me;
  always @(posedge clk) begin
    #1;
    if (done) begin
      chk("done_width", prev_done, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_done: got done=1 expected no frame pending");
      end else begin
        me = sb.pop_front();
        chk("data_out", data_out, me.d);
        chk("crc_ok", crc_ok, me.ok);
        chk("done_latency", cyc, me.c);
`ifdef CRC_ERR_CNT_EN
        if (!me.ok && exp_err < 255) exp_err++;
        chk("err_cnt", err_cnt, exp_err);
`endif
      end
    end
    prev_done = done;
  end

  logic [31:0] d;
  logic [31:0] c;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
`ifdef CRC_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero frame, single-bit payload, corrupted check bits.
    send(32'h00000000, 32'h00000000, 1'b1, -1);
    drain();
    send(32'h00000001, 32'h04C11DB7, 1'b1, -1);
    drain();
    send(32'h00000001, 32'h04C11DB6, 1'b0, -1);
    drain();
    chk("corrupt_data_held", data_out, 32'h00000001);
`ifdef CRC_ERR_CNT_EN
    chk("err_cnt_one", err_cnt, 1);
`endif

    // start re-pulsed at bit 10 must not restart the frame.
    d = 32'hDEADBEEF;
    send(d, crc_model(d), 1'b1, 10);
    drain();

    // Back-to-back frames at minimum spacing, mixed good and bad.
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      c = crc_model(d);
      if (i % 3 == 1) c = c ^ (32'h1 << (i * 5));
      send(d, c, (i % 3 != 1), -1);
    end
    drain();

    // Reset mid-frame after 20 bits: outputs clear at once and no done follows.
    @(negedge clk);
    start = 1'b1;
    data  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      data  = 1'b1;
    end
    rst_n = 1'b0;
`ifdef CRC_ERR_CNT_EN
    exp_err = 0;
`endif
    #1;
    chk("midrst_data_out", data_out, 0);
    chk("midrst_crc_ok", crc_ok, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (3) @(negedge clk);
    data  = 1'b0;
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    d = 32'h12345678;
    send(d, crc_model(d), 1'b1, -1);
    drain();

`ifdef CRC_ERR_CNT_EN
    // Error counter saturates at 8'hFF and holds.
    for (int i = 0; i < 260; i++) begin
      d = $urandom;
      send(d, crc_model(d) ^ 32'h80000000, 1'b0, -1);
    end
    drain();
    chk("err_cnt_sat", err_cnt, 8'hFF);
    repeat (5) @(negedge clk);
    chk("err_cnt_hold", err_cnt, 8'hFF);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
